// File: rtl/riscv_core_fetch_unit_if.sv
// Instruction-memory port of the fetch unit.
// Master side issues word requests, slave side returns words in order.
interface riscv_core_fetch_unit_if #(
  parameter int XLEN = 64
);
  logic            o_fetch_unit_imem_req;
  logic [XLEN-1:0] o_fetch_unit_imem_addr;
  logic [31:0]     i_fetch_unit_imem_rdata;
  logic            i_fetch_unit_imem_rvalid;

  modport master (
    output o_fetch_unit_imem_req,
    output o_fetch_unit_imem_addr,
    input  i_fetch_unit_imem_rdata,
    input  i_fetch_unit_imem_rvalid
  );

  modport slave (
    input  o_fetch_unit_imem_req,
    input  o_fetch_unit_imem_addr,
    output i_fetch_unit_imem_rdata,
    output i_fetch_unit_imem_rvalid
  );
endinterface

// File: rtl/riscv_core_fetch_unit.sv
// IF stage: PC owner, word fetch, 16/32-bit parcel realignment.
// One instruction per cycle into the IF/ID register.
module riscv_core_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_fetch_unit_stall_if,
  input  logic                i_fetch_unit_pcsrc_ex,
  input  logic [XLEN-1:0]     i_fetch_unit_pctarget_ex,
  riscv_core_fetch_unit_if.master imem,
  output logic [31:0]         o_fetch_unit_instr_if,
  output logic [XLEN-1:0]     o_fetch_unit_pc_if,
  output logic [XLEN-1:0]     o_fetch_unit_pcplus_if,
  output logic                o_fetch_unit_compressed_if,
  output logic                o_fetch_unit_valid_if
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {EMPTY, HALF, SPLIT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] faddr_q, faddr_d;
  logic [15:0]     hb_q, hb_d;
  logic            outst_q, outst_d;
  logic            kill_q, kill_d;
  logic            pend_q, pend_d;
  logic [31:0]     skid_q, skid_d;
  logic            skidv_q, skidv_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pco_q, pco_d;
  logic [XLEN-1:0] pcplus_q, pcplus_d;
  logic            comp_q, comp_d;
  logic            valid_q, valid_d;

  logic        redirect, go, resp, resp_live;
  logic        word_v, issue, icomp, consume, step_req, req;
  logic [31:0] word, iinstr;

  assign redirect  = i_fetch_unit_pcsrc_ex;
  assign go        = !i_fetch_unit_stall_if && !redirect;
  assign resp      = imem.i_fetch_unit_imem_rvalid && outst_q;
  assign resp_live = resp && !kill_q;
  assign word_v    = skidv_q || resp_live;
  assign word      = skidv_q ? skid_q : imem.i_fetch_unit_imem_rdata;

  // Parcel realignment FSM: pick the next instruction from word/hb.
  always_comb begin
    state_d  = state_q;
    hb_d     = hb_q;
    pc_d     = pc_q;
    issue    = 1'b0;
    icomp    = 1'b0;
    iinstr   = word;
    consume  = 1'b0;
    step_req = 1'b0;
    if (go) begin
      unique case (state_q)
        EMPTY: begin
          if (word_v) begin
            consume = 1'b1;
            if (!pc_q[1]) begin
              issue = 1'b1;
              if (word[1:0] != 2'b11) begin
                icomp   = 1'b1;
                iinstr  = {16'h0, word[15:0]};
                hb_d    = word[31:16];
                state_d = HALF;
              end else begin
                step_req = 1'b1;
              end
            end else begin
              step_req = 1'b1;
              if (word[17:16] != 2'b11) begin
                issue  = 1'b1;
                icomp  = 1'b1;
                iinstr = {16'h0, word[31:16]};
              end else begin
                hb_d    = word[31:16];
                state_d = SPLIT;
              end
            end
          end
        end
        HALF: begin
          step_req = 1'b1;
          if (hb_q[1:0] != 2'b11) begin
            issue   = 1'b1;
            icomp   = 1'b1;
            iinstr  = {16'h0, hb_q};
            state_d = EMPTY;
          end else begin
            state_d = SPLIT;
          end
        end
        SPLIT: begin
          if (word_v) begin
            consume = 1'b1;
            issue   = 1'b1;
            iinstr  = {word[15:0], hb_q};
            hb_d    = word[31:16];
            state_d = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    if (issue) begin
      pc_d = pc_q + (icomp ? XLEN'(2) : XLEN'(4));
    end
    if (redirect) begin
      state_d = EMPTY;
      hb_d    = '0;
      pc_d    = i_fetch_unit_pctarget_ex & ~XLEN'(1);
    end
  end

  // Request strobe and bookkeeping of the single outstanding fetch.
  always_comb begin
    req     = !rst && go
            && ((pend_q && !outst_q) || step_req);
    outst_d = outst_q;
    kill_d  = kill_q;
    pend_d  = pend_q;
    faddr_d = faddr_q;
    skid_d  = skid_q;
    skidv_d = skidv_q;
    if (resp) outst_d = 1'b0;
    if (req) begin
      outst_d = 1'b1;
      pend_d  = 1'b0;
      faddr_d = faddr_q + XLEN'(4);
    end
    if (resp) kill_d = 1'b0;
    else if (redirect && outst_q) kill_d = 1'b1;
    if (redirect) begin
      pend_d  = 1'b1;
      faddr_d = i_fetch_unit_pctarget_ex & ~XLEN'(3);
      skidv_d = 1'b0;
    end else if (consume) begin
      skidv_d = 1'b0;
    end else if (resp_live) begin
      skid_d  = imem.i_fetch_unit_imem_rdata;
      skidv_d = 1'b1;
    end
  end

  // IF/ID output register: load on issue, hold on stall.
  always_comb begin
    instr_d  = instr_q;
    pco_d    = pco_q;
    pcplus_d = pcplus_q;
    comp_d   = comp_q;
    valid_d  = valid_q;
    if (redirect) begin
      valid_d = 1'b0;
    end else if (!i_fetch_unit_stall_if) begin
      valid_d = issue;
      if (issue) begin
        instr_d  = iinstr;
        pco_d    = pc_q;
        pcplus_d = pc_d;
        comp_d   = icomp;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      pc_q     <= RESET_PC;
      faddr_q  <= RESET_PC & ~XLEN'(3);
      hb_q     <= '0;
      outst_q  <= 1'b0;
      kill_q   <= 1'b0;
      pend_q   <= 1'b1;
      skid_q   <= '0;
      skidv_q  <= 1'b0;
      instr_q  <= NOP;
      pco_q    <= '0;
      pcplus_q <= '0;
      comp_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      faddr_q  <= faddr_d;
      hb_q     <= hb_d;
      outst_q  <= outst_d;
      kill_q   <= kill_d;
      pend_q   <= pend_d;
      skid_q   <= skid_d;
      skidv_q  <= skidv_d;
      instr_q  <= instr_d;
      pco_q    <= pco_d;
      pcplus_q <= pcplus_d;
      comp_q   <= comp_d;
      valid_q  <= valid_d;
    end
  end

  assign imem.o_fetch_unit_imem_req  = req;
  assign imem.o_fetch_unit_imem_addr = rst ? '0 : faddr_q;

  assign o_fetch_unit_instr_if      = instr_q;
  assign o_fetch_unit_pc_if         = pco_q;
  assign o_fetch_unit_pcplus_if     = pcplus_q;
  assign o_fetch_unit_compressed_if = comp_q;
  assign o_fetch_unit_valid_if      = valid_q;
endmodule
